load_store_unit: RTL

- Requester-side master for the CPU's byte-addressed, big-endian data memory port.
- Accepts one load/store request at a time from the execute stage and drives the memory port signals: we, byte-op select, address, write data and combinational read data.
- The memory port supports only aligned word or single-byte accesses. This block splits halfword and misaligned-word accesses into byte beats, assembles load data, and sign- or zero-extends it.
- Returns a single-cycle completion pulse to the pipeline.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and memory-port signals of the load/store unit.
// The unit itself connects through the master modport; the pipeline/memory side uses slave.
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;
  logic                     mem_we;
  logic                     mem_byteop;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_byteop, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_byteop, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian load/store master: splits halfword and misaligned-word accesses into byte
// beats on a word/byte-only memory port, assembles load data and extends it.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst_n,
  load_store_unit_if.master bus
);

  localparam int HALF_WIDTH = 2 * BYTE_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state, state_d;
  logic [1:0]               idx, idx_d;
  logic                     accept;

  logic                     we_q;
  logic                     uns_q;
  logic                     err_q;
  logic                     word_q;
  logic [1:0]               size_q;
  logic [1:0]               last_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    acc_q;

  // Byte k of an n-byte right-justified store value, most significant byte first.
  function automatic logic [BYTE_WIDTH-1:0] beat_byte(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [1:0] sz,
                                                      input logic [1:0] k);
    logic [DATA_WIDTH-1:0] s;
    int unsigned           lead;
    lead = (sz == 2'd0) ? 3 : (sz == 2'd1) ? 2 : 0;
    s    = d << (BYTE_WIDTH * (lead + int'(k)));
    return s[DATA_WIDTH-1 -: BYTE_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_byte(input logic [BYTE_WIDTH-1:0] b,
                                                        input logic zext);
    logic signed [BYTE_WIDTH-1:0] sb;
    logic signed [DATA_WIDTH-1:0] sw;
    sb = b;
    sw = DATA_WIDTH'(sb);
    return zext ? DATA_WIDTH'(b) : sw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_half(input logic [HALF_WIDTH-1:0] h,
                                                        input logic zext);
    logic signed [HALF_WIDTH-1:0] sh;
    logic signed [DATA_WIDTH-1:0] sw;
    sh = h;
    sw = DATA_WIDTH'(sh);
    return zext ? DATA_WIDTH'(h) : sw;
  endfunction

  assign bus.req_ready = rst_n && (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (accept) err_q <= (bus.req_size == 2'b11);
    end
  end

  // Request fields are held for the whole operation; acc collects load bytes MSB first.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      word_q  <= (bus.req_size == 2'b10) && (bus.req_addr[1:0] == 2'b00);
      case (bus.req_size)
        2'b01:   last_q <= 2'd1;
        2'b10:   last_q <= (bus.req_addr[1:0] == 2'b00) ? 2'd0 : 2'd3;
        default: last_q <= 2'd0;
      endcase
    end else if (state == ACCESS && !we_q) begin
      acc_q <= word_q ? bus.mem_rdata
                      : {acc_q[DATA_WIDTH-BYTE_WIDTH-1:0], bus.mem_rdata[BYTE_WIDTH-1:0]};
    end
  end

  always_comb begin
    state_d        = state;
    idx_d          = idx;
    bus.mem_we     = 1'b0;
    bus.mem_byteop = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_err    = 1'b0;
    bus.rsp_rdata  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          idx_d   = 2'd0;
          state_d = (bus.req_size == 2'b11) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_we     = we_q;
        bus.mem_byteop = !word_q;
        bus.mem_addr   = word_q ? addr_q : addr_q + ADDRESS_WIDTH'(idx);
        bus.mem_wdata  = word_q ? wdata_q
                                : {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, beat_byte(wdata_q, size_q, idx)};
        idx_d          = idx + 2'd1;
        if (idx == last_q) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        if (!err_q && !we_q) begin
          case (size_q)
            2'b00:   bus.rsp_rdata = extend_byte(acc_q[BYTE_WIDTH-1:0], uns_q);
            2'b01:   bus.rsp_rdata = extend_half(acc_q[HALF_WIDTH-1:0], uns_q);
            default: bus.rsp_rdata = acc_q;
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset takes effect on the outputs at once so an interrupted store writes nothing more.
    if (!rst_n) begin
      bus.mem_we     = 1'b0;
      bus.mem_byteop = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_err    = 1'b0;
      bus.rsp_rdata  = '0;
    end
  end

endmodule
